// File: rtl/sel_pkg.sv
// Shared encodings for the register select/encode unit: sequencer states,
// field-select codes and the default instruction field layout.
package sel_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_RD_B = 3'd1;
  localparam logic [STATE_W-1:0] S_RD_C = 3'd2;
  localparam logic [STATE_W-1:0] S_WR_A = 3'd3;
  localparam logic [STATE_W-1:0] S_FIN  = 3'd4;

  typedef enum logic [1:0] {
    FLD_NONE = 2'd0,
    FLD_RA   = 2'd1,
    FLD_RB   = 2'd2,
    FLD_RC   = 2'd3
  } fld_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_SEL_W    = 4;
  localparam int DEF_IMM_W    = 15;
  localparam int DEF_RA_LSB   = 23;
  localparam int DEF_RB_LSB   = 19;
  localparam int DEF_RC_LSB   = 15;

endpackage

// File: rtl/onehot_dec.sv
// Register index to one-hot enable decoder; flags indices beyond the file size.
module onehot_dec
  import sel_pkg::*;
#(
  parameter int SEL_W    = DEF_SEL_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic [SEL_W-1:0]    idx_i,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                oor_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot_o[i] = (int'(idx_i) == i);
    end
    oor_o = (int'(idx_i) >= NUM_REGS);
  end

endmodule

// File: rtl/sel_encode_seq.sv
// Select-and-encode unit: private IR copy, one-hot register enables from the
// Ra/Rb/Rc fields (manual strobes or auto sequence) and sign-extended C.
module sel_encode_seq
  import sel_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int IMM_W    = DEF_IMM_W,
  parameter int RA_LSB   = DEF_RA_LSB,
  parameter int RB_LSB   = DEF_RB_LSB,
  parameter int RC_LSB   = DEF_RC_LSB
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                ir_load,
  input  logic [DATA_W-1:0]   ir_in,
  input  logic                g_ra,
  input  logic                g_rb,
  input  logic                g_rc,
  input  logic                r_in,
  input  logic                r_out,
  input  logic                ba_out,
  input  logic                start,
  input  logic                imm_sel,
  input  logic                stall,
  input  logic                err_clr,
  output logic [DATA_W-1:0]   c_out,
  output logic                c_out_en,
  output logic [NUM_REGS-1:0] rx_in,
  output logic [NUM_REGS-1:0] rx_out,
  output logic                ba_zero,
  output logic                busy,
  output logic                done,
  output logic                sel_err
);

  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [STATE_W-1:0]  state_q, state_d;
  logic                imm_sel_q, imm_sel_d;
  logic                stalled_q, stalled_d;
  logic [NUM_REGS-1:0] rx_in_q, rx_in_d;
  logic [NUM_REGS-1:0] rx_out_q, rx_out_d;
  logic                c_out_en_q, c_out_en_d;
  logic                ba_zero_q, ba_zero_d;
  logic                done_q, done_d;
  logic                sel_err_q, sel_err_d;

  logic [STATE_W-1:0]  issue_s;
  logic                man_en;
  logic                manual_any;
  logic [1:0]          g_cnt;
  logic                err_ir, err_seq, err_man, err_rng;
  fld_e                fld_sel;
  logic                want_in, want_out, want_ba, want_c;
  logic [SEL_W-1:0]    fld_idx;
  logic [NUM_REGS-1:0] fld_onehot;
  logic                fld_oor;
  logic                fld_ok;
  logic                unused_ir;

  function automatic logic [STATE_W-1:0] next_step(input logic [STATE_W-1:0] s);
    case (s)
      S_RD_B:  next_step = S_RD_C;
      S_RD_C:  next_step = S_WR_A;
      S_WR_A:  next_step = S_FIN;
      default: next_step = S_IDLE;
    endcase
  endfunction

  assign busy       = (state_q != S_IDLE);
  assign manual_any = g_ra | g_rb | g_rc | r_in | r_out | ba_out;
  assign g_cnt      = {1'b0, g_ra} + {1'b0, g_rb} + {1'b0, g_rc};

  // Sequencer: issue_s names the step whose enables appear next cycle.
  always_comb begin
    state_d   = state_q;
    imm_sel_d = imm_sel_q;
    stalled_d = 1'b0;
    ir_d      = ir_q;
    issue_s   = S_IDLE;
    man_en    = 1'b0;
    err_ir    = 1'b0;
    err_seq   = 1'b0;

    if (ir_load) begin
      if (busy) err_ir = 1'b1;
      else      ir_d   = ir_in;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RD_B;
          imm_sel_d = imm_sel;
          issue_s   = S_RD_B;
          err_seq   = manual_any;
        end else begin
          man_en = 1'b1;
        end
      end
      S_RD_B, S_RD_C, S_WR_A: begin
        err_seq = start | manual_any;
        if (stall) begin
          stalled_d = 1'b1;
        end else begin
          // After a stall the interrupted step is replayed before advancing.
          issue_s = stalled_q ? state_q : next_step(state_q);
          state_d = issue_s;
        end
      end
      S_FIN: begin
        err_seq = start | manual_any;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fld_sel  = FLD_NONE;
    want_in  = 1'b0;
    want_out = 1'b0;
    want_ba  = 1'b0;
    want_c   = 1'b0;
    done_d   = 1'b0;
    err_man  = 1'b0;

    case (issue_s)
      S_RD_B: begin
        fld_sel  = FLD_RB;
        want_out = 1'b1;
      end
      S_RD_C: begin
        if (imm_sel_q) begin
          want_c = 1'b1;
        end else begin
          fld_sel  = FLD_RC;
          want_out = 1'b1;
        end
      end
      S_WR_A: begin
        fld_sel = FLD_RA;
        want_in = 1'b1;
      end
      S_FIN: done_d = 1'b1;
      default: begin
        if (man_en) begin
          err_man = (g_cnt > 2'd1) | (r_in & (r_out | ba_out));
          if (g_ra)      fld_sel = FLD_RA;
          else if (g_rb) fld_sel = FLD_RB;
          else if (g_rc) fld_sel = FLD_RC;
          want_in  = r_in;
          want_out = ~r_in & (r_out | ba_out);
          want_ba  = ~r_in & ba_out;
        end
      end
    endcase
  end

  always_comb begin
    case (fld_sel)
      FLD_RA:  fld_idx = ir_q[RA_LSB +: SEL_W];
      FLD_RB:  fld_idx = ir_q[RB_LSB +: SEL_W];
      FLD_RC:  fld_idx = ir_q[RC_LSB +: SEL_W];
      default: fld_idx = '0;
    endcase
  end

  onehot_dec #(
    .SEL_W    (SEL_W),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .idx_i    (fld_idx),
    .onehot_o (fld_onehot),
    .oor_o    (fld_oor)
  );

  // A base-address read of R0 suppresses the register and asks for a zero bus.
  always_comb begin
    fld_ok     = (fld_sel != FLD_NONE) && !fld_oor;
    err_rng    = (fld_sel != FLD_NONE) && fld_oor && (want_in || want_out);
    rx_in_d    = (want_in && fld_ok) ? fld_onehot : '0;
    ba_zero_d  = want_ba && fld_ok && (fld_idx == '0);
    rx_out_d   = (want_out && fld_ok && !ba_zero_d) ? fld_onehot : '0;
    c_out_en_d = want_c;
    if (err_ir || err_seq || err_man || err_rng) sel_err_d = 1'b1;
    else if (err_clr)                            sel_err_d = 1'b0;
    else                                         sel_err_d = sel_err_q;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ir_q       <= '0;
      state_q    <= S_IDLE;
      imm_sel_q  <= 1'b0;
      stalled_q  <= 1'b0;
      rx_in_q    <= '0;
      rx_out_q   <= '0;
      c_out_en_q <= 1'b0;
      ba_zero_q  <= 1'b0;
      done_q     <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      state_q    <= state_d;
      imm_sel_q  <= imm_sel_d;
      stalled_q  <= stalled_d;
      rx_in_q    <= rx_in_d;
      rx_out_q   <= rx_out_d;
      c_out_en_q <= c_out_en_d;
      ba_zero_q  <= ba_zero_d;
      done_q     <= done_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign c_out     = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign c_out_en  = c_out_en_q;
  assign rx_in     = rx_in_q;
  assign rx_out    = rx_out_q;
  assign ba_zero   = ba_zero_q;
  assign done      = done_q;
  assign sel_err   = sel_err_q;
  assign unused_ir = ^ir_q;

endmodule

// File: tb/tb_sel_encode_seq.sv
// Scoreboard bench for sel_encode_seq: stimulus pushes expected enable events,
// a negedge monitor pops and compares whenever the unit drives anything.
module tb_sel_encode_seq;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        ir_load = 1'b0;
  logic [31:0] ir_in = '0;
  logic        g_ra = 1'b0, g_rb = 1'b0, g_rc = 1'b0;
  logic        r_in = 1'b0, r_out = 1'b0, ba_out = 1'b0;
  logic        start = 1'b0, imm_sel = 1'b0, stall = 1'b0, err_clr = 1'b0;
  logic [31:0] c_out;
  logic        c_out_en;
  logic [15:0] rx_in, rx_out;
  logic        ba_zero, busy, done, sel_err;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        cen;
    logic        baz;
    logic        dn;
  } ev_t;

  ev_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_ir = '0;
  bit          m_err = 1'b0;

  always #5 clock = ~clock;

  sel_encode_seq dut (
    .clock    (clock),
    .clear    (clear),
    .ir_load  (ir_load),
    .ir_in    (ir_in),
    .g_ra     (g_ra),
    .g_rb     (g_rb),
    .g_rc     (g_rc),
    .r_in     (r_in),
    .r_out    (r_out),
    .ba_out   (ba_out),
    .start    (start),
    .imm_sel  (imm_sel),
    .stall    (stall),
    .err_clr  (err_clr),
    .c_out    (c_out),
    .c_out_en (c_out_en),
    .rx_in    (rx_in),
    .rx_out   (rx_out),
    .ba_zero  (ba_zero),
    .busy     (busy),
    .done     (done),
    .sel_err  (sel_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] ir);
    int v;
    v = int'(ir & 32'h7FFF);
    if (v >= 16384) v = v - 32768;
    return 32'(v);
  endfunction

  function automatic logic [15:0] bit_of(input logic [3:0] f);
    return 16'(1) << f;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (clear && (rx_in != 0 || rx_out != 0 || c_out_en || ba_zero || done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {rx_in, rx_out, c_out_en, ba_zero, done}, 64'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event", {rx_in, rx_out, c_out_en, ba_zero, done}, 64'(e));
      end
    end
  end

  task automatic do_load(input logic [31:0] v);
    ir_load = 1'b1;
    ir_in   = v;
    step();
    ir_load = 1'b0;
    m_ir    = v;
    chk("c_out", c_out, sext(v));
  endtask

  task automatic do_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_err   = 1'b0;
    chk("err_clr", sel_err, 0);
  endtask

  task automatic do_manual(input logic ga, gb, gc, ri, ro, bo);
    ev_t         e;
    int          cnt;
    logic [3:0]  f;
    cnt = int'(ga) + int'(gb) + int'(gc);
    e = '0;
    if (cnt > 0) begin
      f = ga ? m_ir[26:23] : (gb ? m_ir[22:19] : m_ir[18:15]);
      if (ri)                e.rin  = bit_of(f);
      else if (bo && f == 0) e.baz  = 1'b1;
      else if (ro || bo)     e.rout = bit_of(f);
    end
    if (e != '0) exp_q.push_back(e);
    if (cnt > 1 || (ri && (ro || bo))) m_err = 1'b1;
    g_ra = ga; g_rb = gb; g_rc = gc; r_in = ri; r_out = ro; ba_out = bo;
    step();
    g_ra = 1'b0; g_rb = 1'b0; g_rc = 1'b0; r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
    step();
    chk("manual_sel_err", sel_err, m_err);
  endtask

  // inj: 0 none, 1 start, 2 manual read strobe, 3 ir_load -- all in busy cycle 2
  task automatic do_auto(input logic isel, input int s, input int l, input int inj);
    ev_t st[3];
    ev_t e;
    int  extra, busy_cnt, done_cyc;
    bit  fin;
    st[0] = '0; st[0].rout = bit_of(m_ir[22:19]);
    st[1] = '0;
    if (isel) st[1].cen  = 1'b1;
    else      st[1].rout = bit_of(m_ir[18:15]);
    st[2] = '0; st[2].rin = bit_of(m_ir[26:23]);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(st[k]);
      if (l > 0 && k == s) exp_q.push_back(st[k]);
    end
    e = '0; e.dn = 1'b1;
    exp_q.push_back(e);
    extra = (l > 0) ? l + 1 : 0;

    start = 1'b1; imm_sel = isel;
    step();
    start = 1'b0;
    busy_cnt = 0; done_cyc = -1; fin = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      imm_sel = 1'($urandom_range(0, 1));
      stall   = (l > 0 && cyc >= s + 1 && cyc <= s + l);
      start   = (inj == 1 && cyc == 2);
      g_rb    = (inj == 2 && cyc == 2);
      r_out   = (inj == 2 && cyc == 2);
      ir_load = (inj == 3 && cyc == 2);
      ir_in   = $urandom;
      if (done) done_cyc = cyc;
      if (!busy) begin
        fin = 1'b1;
        break;
      end
      busy_cnt++;
      step();
    end
    stall = 1'b0; start = 1'b0; g_rb = 1'b0; r_out = 1'b0; ir_load = 1'b0; imm_sel = 1'b0;
    if (inj != 0) m_err = 1'b1;
    chk("auto_finished", fin, 1);
    chk("busy_cycles", busy_cnt, 4 + extra);
    chk("done_cycle", done_cyc, 4 + extra);
    chk("auto_sel_err", sel_err, m_err);
    chk("auto_c_out", c_out, sext(m_ir));
  endtask

  initial begin
    ev_t e;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rx_in", rx_in, 0);
    chk("rst_busy", busy, 0);
    clear = 1'b1;
    step();
    chk("rst_c_out", c_out, 0);
    chk("rst_rx_out", rx_out, 0);
    chk("rst_c_out_en", c_out_en, 0);
    chk("rst_ba_zero", ba_zero, 0);
    chk("rst_done", done, 0);
    chk("rst_sel_err", sel_err, 0);

    do_load(32'h011A_4005);
    chk("c_out_example", c_out, 32'hFFFF_C005);
    do_manual(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_auto(1'b0, 0, 0, 0);
    do_auto(1'b1, 1, 2, 0);

    do_load(32'h0102_4005);
    do_manual(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    do_load(32'h011A_4005);

    do_manual(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    chk("sel_err_held", sel_err, 1);
    do_clr();

    g_ra = 1'b1; g_rb = 1'b1; err_clr = 1'b1;
    step();
    g_ra = 1'b0; g_rb = 1'b0; err_clr = 1'b0;
    m_err = 1'b1;
    chk("set_beats_clr", sel_err, 1);
    do_clr();

    do_auto(1'b0, 0, 0, 1);
    do_clr();
    do_auto(1'b1, 2, 1, 2);
    do_clr();
    do_auto(1'b0, 0, 3, 3);
    do_clr();

    // asynchronous clear while the write enable is showing
    for (int k = 0; k < 3; k++) begin
      e = '0;
      if (k == 0) e.rout = 16'h0008;
      if (k == 1) e.rout = 16'h0010;
      if (k == 2) e.rin  = 16'h0004;
      exp_q.push_back(e);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_wr_a", rx_in, 16'h0004);
    @(negedge clock);
    #1;
    clear = 1'b0;
    #1;
    chk("clr_rx_in", rx_in, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    chk("clr_c_out", c_out, 0);
    step();
    step();
    clear = 1'b1;
    m_ir = '0;
    m_err = 1'b0;
    step();
    chk("clr_no_done", done, 0);
    chk("clr_queue", exp_q.size(), 0);

    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        do_load($urandom);
      end else if (r <= 5) begin
        do_manual(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      end else if (r <= 8) begin
        do_auto(1'($urandom_range(0, 1)), $urandom_range(0, 2),
                ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end else begin
        do_clr();
      end
    end

    step();
    step();
    chk("final_queue", exp_q.size(), 0);
    chk("final_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
